// File: rtl/ahb_generic_subordinate.sv
// AHB-Lite subordinate that replays accepted transfers as single generic-bus requests.
// It decodes the address window and answers bad transfers with a two-cycle ERROR response.
module ahb_generic_subordinate #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] RANGE_BYTES = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  // AHB side
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  // generic bus side
  output logic        ren,
  output logic        wen,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  byte_en,
  input  logic        busy,
  input  logic [31:0] rdata
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ERR1,
    ERR2
  } state_t;

  state_t          state, state_next;
  logic            write_q;
  logic [AW-1:0]   addr_q;
  logic [BEW-1:0]  be_q;

  logic [BEW-1:0]  be_dec;
  logic            size_err;
  logic            in_window;
  logic            xfer_err;
  logic            accept;
  logic            slot_free;
  logic            take;
  logic            ren_int;
  logic            wen_int;
  logic            hreadyout_int;
  logic            hresp_int;
  logic [DW-1:0]   hrdata_int;

  // Address-phase decode: lane enables plus size/alignment faults.
  always_comb begin
    be_dec   = '0;
    size_err = 1'b0;
    case (HSIZE)
      3'b000: be_dec = BEW'(4'b0001 << HADDR[1:0]);
      3'b001: begin
        be_dec   = HADDR[1] ? 4'b1100 : 4'b0011;
        size_err = HADDR[0];
      end
      3'b010: begin
        be_dec   = 4'b1111;
        size_err = |HADDR[1:0];
      end
      default: size_err = 1'b1;
    endcase
  end

  assign in_window = ((HADDR & ~(RANGE_BYTES - AW'(1))) == BASE_ADDR);
  assign xfer_err  = size_err | ~in_window;
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign take      = accept & slot_free;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-state bus responses; slot_free marks the cycle a new transfer may start.
  always_comb begin
    state_next    = state;
    slot_free     = 1'b0;
    ren_int       = 1'b0;
    wen_int       = 1'b0;
    hreadyout_int = 1'b1;
    hresp_int     = 1'b0;
    hrdata_int    = '0;
    case (state)
      IDLE: begin
        slot_free = 1'b1;
      end
      ACCESS: begin
        ren_int       = ~write_q;
        wen_int       = write_q;
        hreadyout_int = ~busy;
        hrdata_int    = write_q ? '0 : rdata;
        slot_free     = ~busy;
      end
      ERR1: begin
        hresp_int     = 1'b1;
        hreadyout_int = 1'b0;
        state_next    = ERR2;
      end
      ERR2: begin
        hresp_int = 1'b1;
        slot_free = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (slot_free) begin
      if (accept) begin
        state_next = xfer_err ? ERR1 : ACCESS;
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Captured address phase, replayed downstream during ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
    end else if (take) begin
      write_q <= HWRITE;
      addr_q  <= {HADDR[AW-1:2], 2'b00};
      be_q    <= be_dec;
    end
  end

  // Strobes are masked by reset so an in-flight request drops immediately.
  assign ren       = ren_int & nRST;
  assign wen       = wen_int & nRST;
  assign addr      = addr_q;
  assign byte_en   = be_q;
  assign wdata     = HWDATA;
  assign HREADYOUT = hreadyout_int;
  assign HRESP     = hresp_int;
  assign HRDATA    = hrdata_int;

endmodule

// File: tb/tb_ahb_generic_subordinate.sv
// Directed bench for ahb_generic_subordinate: reset, word/byte/half transfers, pipelining,
// error responses and IDLE/BUSY handling, checked with immediate assertions.
module tb_ahb_generic_subordinate;

  logic        CLK;
  logic        nRST;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byte_en;
  logic        busy;
  logic [31:0] rdata;

  int n_checks;
  int n_fail;

  ahb_generic_subordinate #(
    .BASE_ADDR  (32'h0000_0000),
    .RANGE_BYTES(32'h0001_0000)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .HSEL     (HSEL),
    .HTRANS   (HTRANS),
    .HWRITE   (HWRITE),
    .HSIZE    (HSIZE),
    .HADDR    (HADDR),
    .HWDATA   (HWDATA),
    .HREADY   (HREADY),
    .HREADYOUT(HREADYOUT),
    .HRESP    (HRESP),
    .HRDATA   (HRDATA),
    .ren      (ren),
    .wen      (wen),
    .addr     (addr),
    .wdata    (wdata),
    .byte_en  (byte_en),
    .busy     (busy),
    .rdata    (rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HSIZE  = sz;
    HADDR  = a;
  endtask

  task automatic idle_bus();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b000;
    HADDR  = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  err_size [3];
    logic [31:0] err_addr [3];
    n_checks = 0;
    n_fail   = 0;
    err_size[0] = 3'b010; err_addr[0] = 32'h0000_0002;
    err_size[1] = 3'b011; err_addr[1] = 32'h0000_0000;
    err_size[2] = 3'b010; err_addr[2] = 32'h0001_0000;

    nRST   = 1'b0;
    HREADY = 1'b1;
    busy   = 1'b0;
    rdata  = 32'h0;
    HWDATA = 32'hA5A5_A5A5;
    idle_bus();

    // Reset values
    #2;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("rst_hresp",     32'(HRESP),     32'h0);
    chk("rst_hrdata",    HRDATA,         32'h0);
    chk("rst_ren",       32'(ren),       32'h0);
    chk("rst_wen",       32'(wen),       32'h0);
    chk("rst_addr",      addr,           32'h0);
    chk("rst_byte_en",   32'(byte_en),   32'h0);
    chk("rst_wdata",     wdata,          32'hA5A5_A5A5);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Zero-wait word write to 0x10
    addr_phase(1'b1, 3'b010, 32'h0000_0010);
    #1 chk("ww_aphase_ready", 32'(HREADYOUT), 32'h1);
    @(negedge CLK);
    idle_bus();
    HWDATA = 32'hDEAD_BEEF;
    #1;
    chk("ww_wen",       32'(wen),       32'h1);
    chk("ww_ren",       32'(ren),       32'h0);
    chk("ww_addr",      addr,           32'h0000_0010);
    chk("ww_byte_en",   32'(byte_en),   32'hF);
    chk("ww_wdata",     wdata,          32'hDEAD_BEEF);
    chk("ww_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("ww_hresp",     32'(HRESP),     32'h0);
    chk("ww_hrdata",    HRDATA,         32'h0);
    @(negedge CLK);
    #1 chk("ww_done_wen", 32'(wen), 32'h0);

    // Byte read at 0x7 with three busy cycles
    @(negedge CLK);
    addr_phase(1'b0, 3'b000, 32'h0000_0007);
    @(negedge CLK);
    idle_bus();
    rdata = 32'h1122_3344;
    for (int i = 0; i < 3; i++) begin
      busy = 1'b1;
      #1;
      chk("br_wait_ren",       32'(ren),       32'h1);
      chk("br_wait_hreadyout", 32'(HREADYOUT), 32'h0);
      chk("br_byte_en",        32'(byte_en),   32'h8);
      chk("br_addr",           addr,           32'h0000_0004);
      @(negedge CLK);
    end
    busy = 1'b0;
    #1;
    chk("br_last_ren",       32'(ren),       32'h1);
    chk("br_last_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("br_hrdata",         HRDATA,         32'h1122_3344);
    @(negedge CLK);
    #1;
    chk("br_done_ren",    32'(ren), 32'h0);
    chk("br_done_hrdata", HRDATA,   32'h0);

    // Back-to-back half write at 0x2 then word read at 0x4
    @(negedge CLK);
    addr_phase(1'b1, 3'b001, 32'h0000_0002);
    @(negedge CLK);
    addr_phase(1'b0, 3'b010, 32'h0000_0004);
    HWDATA = 32'h0000_CAFE;
    #1;
    chk("pl_wen",       32'(wen),       32'h1);
    chk("pl_w_byte_en", 32'(byte_en),   32'hC);
    chk("pl_w_addr",    addr,           32'h0000_0000);
    chk("pl_w_ready",   32'(HREADYOUT), 32'h1);
    @(negedge CLK);
    idle_bus();
    rdata = 32'h5566_7788;
    #1;
    chk("pl_ren",       32'(ren),     32'h1);
    chk("pl_r_wen",     32'(wen),     32'h0);
    chk("pl_r_byte_en", 32'(byte_en), 32'hF);
    chk("pl_r_addr",    addr,         32'h0000_0004);
    chk("pl_r_hrdata",  HRDATA,       32'h5566_7788);
    @(negedge CLK);
    #1 chk("pl_done_ren", 32'(ren), 32'h0);

    // Misaligned word, oversized transfer, out-of-window address
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      addr_phase(1'b0, err_size[k], err_addr[k]);
      @(negedge CLK);
      idle_bus();
      #1;
      chk("err1_hresp",     32'(HRESP),     32'h1);
      chk("err1_hreadyout", 32'(HREADYOUT), 32'h0);
      chk("err1_strobe",    32'({ren, wen}), 32'h0);
      @(negedge CLK);
      #1;
      chk("err2_hresp",     32'(HRESP),     32'h1);
      chk("err2_hreadyout", 32'(HREADYOUT), 32'h1);
      chk("err2_strobe",    32'({ren, wen}), 32'h0);
      @(negedge CLK);
      #1;
      chk("err_after_hresp",  32'(HRESP),      32'h0);
      chk("err_after_strobe", 32'({ren, wen}), 32'h0);
    end

    // IDLE and BUSY transfers: OKAY, no strobe, stays idle (busy ignored)
    @(negedge CLK);
    HSEL   = 1'b1;
    HTRANS = 2'b00;
    HWRITE = 1'b1;
    HSIZE  = 3'b010;
    HADDR  = 32'h0000_0040;
    #1;
    chk("idle_hreadyout", 32'(HREADYOUT), 32'h1);
    chk("idle_hresp",     32'(HRESP),     32'h0);
    @(negedge CLK);
    HTRANS = 2'b01;
    busy   = 1'b1;
    #1;
    chk("busyt_hreadyout", 32'(HREADYOUT),  32'h1);
    chk("busyt_strobe",    32'({ren, wen}), 32'h0);
    @(negedge CLK);
    idle_bus();
    #1;
    chk("busyt_after_hreadyout", 32'(HREADYOUT),  32'h1);
    chk("busyt_after_strobe",    32'({ren, wen}), 32'h0);
    busy = 1'b0;

    // Reset pulse in the middle of a stalled read
    @(negedge CLK);
    addr_phase(1'b0, 3'b010, 32'h0000_0020);
    @(negedge CLK);
    idle_bus();
    busy = 1'b1;
    #1;
    chk("mr_ren_before",   32'(ren),       32'h1);
    chk("mr_ready_before", 32'(HREADYOUT), 32'h0);
    #1 nRST = 1'b0;
    #1;
    chk("mr_ren_in_rst",   32'(ren),       32'h0);
    chk("mr_wen_in_rst",   32'(wen),       32'h0);
    chk("mr_ready_in_rst", 32'(HREADYOUT), 32'h1);
    chk("mr_addr_in_rst",  addr,           32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    chk("mr_idle_ready", 32'(HREADYOUT), 32'h1);
    chk("mr_idle_ren",   32'(ren),       32'h0);
    busy = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_generic_subordinate.md
# ahb_generic_subordinate

AHB-Lite subordinate that accepts pipelined AHB transfers and replays them as single generic-bus requests toward a memory or peripheral. It is the responder-side counterpart of the core's AHB manager bridge, and sits between the AHB interconnect and any block exposing a `generic_bus_if`. The block also decodes the address window, checks alignment and size, and issues two-cycle ERROR responses for bad transfers.

## Interface
- `BASE_ADDR`, default `32'h0000_0000`: first byte address of the decoded window; must be aligned to `RANGE_BYTES`.
- `RANGE_BYTES`, default `32'h0001_0000`: window size; must be a power of two.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ahb_s`  `ahb_if.subordinate`  —  AHB side.
  - Inputs: `HSEL`, `HTRANS[1:0]`, `HWRITE`, `HSIZE[2:0]`, `HADDR[31:0]`, `HWDATA[31:0]`, `HREADY`.
  - Driven by this block: `HREADYOUT`, `HRESP`, `HRDATA[31:0]`.
- `gen_m`  `generic_bus_if.cpu`  —  downstream side.
  - Driven by this block: `ren`, `wen`, `addr[31:0]`, `wdata[31:0]`, `byte_en[3:0]`.
  - Inputs: `busy`, `rdata[31:0]`.

## Operation
- **Address-phase accept.** Accept when `HSEL & HREADY & HTRANS[1]` (NONSEQ or SEQ). On accept, register `HWRITE`, `{HADDR[31:2],2'b00}`, the computed `byte_en`, and an error flag.
- **IDLE/BUSY transfers.** When `HSEL` is high with `HTRANS` = 00 or 01, respond zero-wait OKAY with no downstream access. Unselected cycles are ignored.
- **byte_en from HSIZE.**
  - 000 (byte): `4'b0001 << HADDR[1:0]`.
  - 001 (half): `HADDR[1]` ? `4'b1100` : `4'b0011`.
  - 010 (word): `4'b1111`.
- **Error conditions.** Any of the following sets the error flag:
  - `HSIZE > 3'b010`;
  - misaligned half (`HADDR[0]=1`) or misaligned word (`HADDR[1:0]!=0`);
  - `HADDR` outside `[BASE_ADDR, BASE_ADDR+RANGE_BYTES)`, where the in-window check is `(HADDR & ~(RANGE_BYTES-1)) == BASE_ADDR`.
- **FSM states.**
  - `IDLE`
    - Outputs: `HREADYOUT=1`, `HRESP=0`, `ren=wen=0`.
    - Transitions: an accepted transfer without error goes to `ACCESS`; an accepted transfer with error goes to `ERR1`.
  - `ACCESS`
    - Outputs: `ren=~write_q` and `wen=write_q`; `addr`/`byte_en` come from the registers; `wdata=HWDATA` (live); `HREADYOUT=~busy`; `HRDATA=rdata` (0 on writes).
    - Transitions: while `busy`, stay. When `busy` is low the transfer completes that cycle; the next state is `ACCESS`/`ERR1` if a new transfer is accepted that cycle, otherwise `IDLE`.
  - `ERR1`
    - Outputs: `HRESP=1`, `HREADYOUT=0`, no downstream access.
    - Transitions: always go to `ERR2`.
  - `ERR2`
    - Outputs: `HRESP=1`, `HREADYOUT=1`.
    - Transitions: same next-state rule as `ACCESS` completion.
- **Downstream protocol.** `ren`/`wen` are held with stable `addr`/`byte_en`/`wdata` until `busy` is low. Exactly one request is issued per accepted good transfer.
- **HRDATA.** 0 in every state except `ACCESS` reads.
- **Reset mid-operation.** Any in-flight downstream request is dropped combinationally. All registers clear and the FSM goes to `IDLE`.

## Timing
- Reset values:
  - `HREADYOUT=1`, `HRESP=0`, `HRDATA=0`;
  - `ren=0`, `wen=0`, `addr=0`, `byte_en=0`, `wdata` follows `HWDATA`;
  - state `IDLE`.
- The address phase is sampled at edge N. `ren`/`wen` assert in cycle N+1 (data phase); they are registered-state driven, with no combinational path from `HTRANS`.
- The data phase lasts 1 + (number of cycles `busy` is high in `ACCESS`). A zero-wait target (`busy` low in the first `ACCESS` cycle) gives single-cycle data phases.
- Back-to-back transfers are sustained at 1 per cycle with zero-wait targets: the address phase of transfer k+1 overlaps the completing data phase of transfer k.
- An error response is exactly 2 data-phase cycles. The `HRESP=1, HREADYOUT=0` cycle always precedes the `HRESP=1, HREADYOUT=1` cycle.
- Address phases arriving while `HREADY=0` are not sampled. The manager holds or retracts them per AHB-Lite rules.

## Test plan
- **Reset.** Pulse `nRST` low mid-`ACCESS` with `busy=1` -> the same cycle gives `ren=wen=0` and `HREADYOUT=1`; the next cycle is in `IDLE`.
- **Word write.** Zero-wait word write to `BASE_ADDR+0x10`, `HWDATA=0xDEADBEEF` -> one cycle with `wen=1`, `addr=0x10`, `byte_en=1111`, `wdata=0xDEADBEEF`; `HREADYOUT=1`, `HRESP=0`.
- **Waited byte read.** Byte read at `BASE+0x7` with `busy` high for 3 cycles, `rdata=0x11223344` -> `byte_en=1000`; `HREADYOUT` low for 3 cycles, then high with `HRDATA=0x11223344`; `ren` is high for exactly 4 cycles.
- **Pipelined stream.** Half write at `0x2` followed by word read at `0x4`, back-to-back with zero-wait -> consecutive cycles `wen,byte_en=1100` then `ren,byte_en=1111`; no bubble.
- **Error cases.** Word access at `0x2`, `HSIZE=011`, and an address `BASE+RANGE_BYTES` -> each gives `HRESP=1/HREADYOUT=0` then `HRESP=1/HREADYOUT=1`, with `ren=wen=0` throughout.
- **IDLE/BUSY.** `HSEL=1`, `HTRANS=00`/`01` -> OKAY zero-wait, no downstream strobe, state stays `IDLE`.
